// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and the memory-stage decode.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Y86 icodes that reach the memory stage; decode and arbiter share these.
  localparam logic [3:0] RMMOVQ = 4'd4;
  localparam logic [3:0] MRMOVQ = 4'd5;
  localparam logic [3:0] CALL   = 4'd8;
  localparam logic [3:0] RET    = 4'd9;
  localparam logic [3:0] PUSHQ  = 4'd10;
  localparam logic [3:0] POPQ   = 4'd11;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [63:0] data;
  } rsp_t;

  // Full-width compare so high address bits can never alias into the array.
  function automatic logic addr_bad(input logic [63:0] addr, input int unsigned words);
    return addr >= 64'(words);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin grant: under contention the requester that did not win last goes first.
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic req_f_i,
  input  logic req_d_i,
  input  logic take_i,
  output logic gnt_o,
  output logic gnt_id_o
);

  logic rr_last_q;

  always_comb begin
    gnt_o = req_f_i | req_d_i;
    if (req_f_i && req_d_i) gnt_id_o = ~rr_last_q;
    else                    gnt_id_o = req_d_i ? REQ_D : REQ_F;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                rr_last_q <= REQ_D;
    else if (take_i && gnt_o)    rr_last_q <= gnt_id_o;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between fetch (F) and memory-stage (D) requesters
// with a registered request/ack handshake, address range check and wait-state timeout.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT   = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [63:0]       f_addr,
  output logic              f_valid,
  output logic [63:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_valid,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic [63:0]       m_rdata,
  input  logic              m_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              idle, gnt, gnt_id;
  logic              id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_en_q, m_en_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [63:0]       m_wdata_q, m_wdata_d;
  rsp_t              f_rsp_q, f_rsp_d, d_rsp_q, d_rsp_d;
  rsp_t              rsp;
  logic              rsp_id;
  logic [63:0]       sel_addr;
  logic              sel_we, sel_bad, tmo;

  assign idle = (state_q == IDLE);

  dmem_rr_pick u_rr (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_f_i  (f_req),
    .req_d_i  (d_req),
    .take_i   (idle),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // F is read-only, so only a D grant can produce a write.
  assign sel_addr = (gnt_id == REQ_D) ? d_addr : f_addr;
  assign sel_we   = (gnt_id == REQ_D) && d_we;
  assign sel_bad  = addr_bad(sel_addr, MEM_WORDS);
  assign tmo      = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = sel_bad ? RESP : BUSY;
      BUSY:    if (m_ack || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d      = id_q;
    cnt_d     = cnt_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = '0;
    m_wdata_d = '0;
    rsp       = '0;
    rsp_id    = id_q;
    case (state_q)
      IDLE: if (gnt) begin
        id_d   = gnt_id;
        rsp_id = gnt_id;
        cnt_d  = '0;
        if (sel_bad) begin
          rsp.vld = 1'b1;
          rsp.err = 1'b1;
        end else begin
          m_en_d    = 1'b1;
          m_we_d    = sel_we;
          m_addr_d  = sel_addr[ADDR_W-1:0];
          m_wdata_d = sel_we ? d_wdata : '0;
        end
      end
      BUSY: begin
        if (m_ack) begin
          rsp.vld  = 1'b1;
          rsp.data = m_we_q ? 64'd0 : m_rdata;
        end else if (tmo) begin
          rsp.vld = 1'b1;
          rsp.err = 1'b1;
        end else begin
          m_en_d    = 1'b1;
          m_we_d    = m_we_q;
          m_addr_d  = m_addr_q;
          m_wdata_d = m_wdata_q;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    f_rsp_d = (rsp_id == REQ_F) ? rsp : '0;
    d_rsp_d = (rsp_id == REQ_D) ? rsp : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q      <= REQ_F;
      cnt_q     <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      f_rsp_q   <= '0;
      d_rsp_q   <= '0;
    end else begin
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      f_rsp_q   <= f_rsp_d;
      d_rsp_q   <= d_rsp_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign f_valid = f_rsp_q.vld;
  assign f_err   = f_rsp_q.err;
  assign f_rdata = f_rsp_q.data;
  assign d_valid = d_rsp_q.vld;
  assign d_err   = d_rsp_q.err;
  assign d_rdata = d_rsp_q.data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory that acks after ack_wait wait states.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_valid, f_err;
  logic [63:0] f_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic        d_valid, d_err;
  logic [63:0] d_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  int tests = 0, fails = 0;
  int ack_wait = 0, en_cnt = 0, acc_cnt = 0, fv_cnt = 0, dv_cnt = 0;
  logic [63:0] mem [0:1023];

  dmem_arbiter #(.MEM_WORDS(1024), .ADDR_W(10), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clock = ~clock;

  // Memory model and response monitors, updated on the falling edge.
  always @(negedge clock) begin
    if (m_en) begin
      if (en_cnt == 0) acc_cnt++;
      m_ack   = (en_cnt == ack_wait);
      m_rdata = mem[m_addr];
      if (m_ack && m_we) mem[m_addr] = m_wdata;
      en_cnt++;
    end else begin
      m_ack  = 1'b0;
      en_cnt = 0;
    end
    if (f_valid) fv_cnt++;
    if (d_valid) dv_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    tests++;
    if ({m_en, m_we, m_addr, m_wdata, f_valid, f_rdata, f_err, d_valid, d_rdata, d_err} !== '0) begin
      $display("FAIL reset_outputs: got %h want 0",
               {m_en, m_we, m_addr, m_wdata, f_valid, f_rdata, f_err, d_valid, d_rdata, d_err});
      fails++;
    end
    reset_n = 1'b1;
    tick;
    tests++;
    if ({m_en, f_valid, d_valid} !== 3'b000) begin
      $display("FAIL reset_idle: got %b want 000", {m_en, f_valid, d_valid});
      fails++;
    end
  endtask

  task automatic test_write_read;
    ack_wait = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd5; d_wdata = 64'hAB;
    tick;
    tests++;
    if ({m_en, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 10'd5, 64'hAB}) begin
      $display("FAIL wr_strobe: got %h want %h", {m_en, m_we, m_addr, m_wdata}, {1'b1, 1'b1, 10'd5, 64'hAB});
      fails++;
    end
    tests++;
    if (d_valid !== 1'b0) begin
      $display("FAIL wr_early_valid: got %b want 0", d_valid);
      fails++;
    end
    tick;
    tests++;
    if ({d_valid, d_err, d_rdata, m_en} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      $display("FAIL wr_resp: got %h want %h", {d_valid, d_err, d_rdata, m_en}, {1'b1, 1'b0, 64'h0, 1'b0});
      fails++;
    end
    d_req = 1'b0; d_we = 1'b0;
    tick;
    d_req = 1'b1; d_addr = 64'd5;
    tick;
    tests++;
    if ({m_en, m_we, m_addr} !== {1'b1, 1'b0, 10'd5}) begin
      $display("FAIL rd_strobe: got %h want %h", {m_en, m_we, m_addr}, {1'b1, 1'b0, 10'd5});
      fails++;
    end
    tick;
    tests++;
    if ({d_valid, d_err, d_rdata} !== {1'b1, 1'b0, 64'hAB}) begin
      $display("FAIL rd_after_wr: got %h want %h", {d_valid, d_err, d_rdata}, {1'b1, 1'b0, 64'hAB});
      fails++;
    end
    d_req = 1'b0;
    tick;
  endtask

  task automatic test_arbitration;
    f_req = 1'b1; f_addr = 64'd7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd5;
    tick;
    tests++;
    if ({m_en, m_we, m_addr} !== {1'b1, 1'b0, 10'd7}) begin
      $display("FAIL arb_first_f: got %h want %h", {m_en, m_we, m_addr}, {1'b1, 1'b0, 10'd7});
      fails++;
    end
    tick;
    tests++;
    if ({f_valid, d_valid, f_rdata} !== {1'b1, 1'b0, 64'h1007}) begin
      $display("FAIL arb_f_resp: got %h want %h", {f_valid, d_valid, f_rdata}, {1'b1, 1'b0, 64'h1007});
      fails++;
    end
    tick; tick;
    tests++;
    if ({m_en, m_addr} !== {1'b1, 10'd5}) begin
      $display("FAIL arb_then_d: got %h want %h", {m_en, m_addr}, {1'b1, 10'd5});
      fails++;
    end
    tick;
    tests++;
    if ({f_valid, d_valid, d_rdata} !== {1'b0, 1'b1, 64'hAB}) begin
      $display("FAIL arb_d_resp: got %h want %h", {f_valid, d_valid, d_rdata}, {1'b0, 1'b1, 64'hAB});
      fails++;
    end
    tick; tick;
    tests++;
    if ({m_en, m_addr} !== {1'b1, 10'd7}) begin
      $display("FAIL arb_f_again: got %h want %h", {m_en, m_addr}, {1'b1, 10'd7});
      fails++;
    end
    tick;
    tests++;
    if ({f_valid, d_valid} !== 2'b10) begin
      $display("FAIL arb_alt_resp: got %b want 10", {f_valid, d_valid});
      fails++;
    end
    f_req = 1'b0; d_req = 1'b0;
    tick;
  endtask

  task automatic test_bad_addr;
    int a0;
    a0 = acc_cnt;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd1024;
    tick;
    tests++;
    if ({d_valid, d_err, d_rdata, m_en, f_valid} !== {1'b1, 1'b1, 64'h0, 1'b0, 1'b0}) begin
      $display("FAIL bad_d_1024: got %h want %h", {d_valid, d_err, d_rdata, m_en, f_valid},
               {1'b1, 1'b1, 64'h0, 1'b0, 1'b0});
      fails++;
    end
    d_req = 1'b0;
    tick;
    tests++;
    if (m_en !== 1'b0) begin
      $display("FAIL bad_no_strobe: got %b want 0", m_en);
      fails++;
    end
    f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_0003;
    tick;
    tests++;
    if ({f_valid, f_err, f_rdata, m_en} !== {1'b1, 1'b1, 64'h0, 1'b0}) begin
      $display("FAIL bad_f_high: got %h want %h", {f_valid, f_err, f_rdata, m_en}, {1'b1, 1'b1, 64'h0, 1'b0});
      fails++;
    end
    f_req = 1'b0;
    tick;
    tests++;
    if (acc_cnt !== a0) begin
      $display("FAIL bad_mem_touched: got %0d want %0d", acc_cnt, a0);
      fails++;
    end
    d_req = 1'b1; d_addr = 64'd1023;
    tick;
    tests++;
    if ({m_en, m_addr} !== {1'b1, 10'd1023}) begin
      $display("FAIL edge_1023_strobe: got %h want %h", {m_en, m_addr}, {1'b1, 10'd1023});
      fails++;
    end
    tick;
    tests++;
    if ({d_valid, d_err, d_rdata} !== {1'b1, 1'b0, 64'h13FF}) begin
      $display("FAIL edge_1023_resp: got %h want %h", {d_valid, d_err, d_rdata}, {1'b1, 1'b0, 64'h13FF});
      fails++;
    end
    d_req = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    int vc;
    ack_wait = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd2;
    vc = 0;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (d_valid) begin vc = c; break; end
    end
    tests++;
    if (vc !== 16) begin
      $display("FAIL tmo_cycle: got %0d want 16", vc);
      fails++;
    end
    tests++;
    if ({d_err, d_rdata, m_en} !== {1'b1, 64'h0, 1'b0}) begin
      $display("FAIL tmo_resp: got %h want %h", {d_err, d_rdata, m_en}, {1'b1, 64'h0, 1'b0});
      fails++;
    end
    d_req = 1'b0;
    tick;
    ack_wait = 3;
    f_req = 1'b1; f_addr = 64'd9;
    vc = 0;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (f_valid) begin vc = c; break; end
    end
    tests++;
    if (vc !== 5) begin
      $display("FAIL wait3_cycle: got %0d want 5", vc);
      fails++;
    end
    tests++;
    if ({f_err, f_rdata} !== {1'b0, 64'h1009}) begin
      $display("FAIL wait3_resp: got %h want %h", {f_err, f_rdata}, {1'b0, 64'h1009});
      fails++;
    end
    f_req = 1'b0;
    ack_wait = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    int fv0;
    ack_wait = 100;
    f_req = 1'b1; f_addr = 64'd4;
    tick;
    tests++;
    if (m_en !== 1'b1) begin
      $display("FAIL rst_mid_busy: got %b want 1", m_en);
      fails++;
    end
    tick;
    fv0 = fv_cnt;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({m_en, f_valid, d_valid} !== 3'b000) begin
      $display("FAIL rst_mid_async: got %b want 000", {m_en, f_valid, d_valid});
      fails++;
    end
    tick; tick;
    reset_n = 1'b1;
    ack_wait = 0;
    tests++;
    if (fv_cnt !== fv0) begin
      $display("FAIL rst_mid_pulse: got %0d want %0d", fv_cnt, fv0);
      fails++;
    end
    tick;
    tests++;
    if ({m_en, m_addr} !== {1'b1, 10'd4}) begin
      $display("FAIL rst_regrant: got %h want %h", {m_en, m_addr}, {1'b1, 10'd4});
      fails++;
    end
    tick;
    tests++;
    if ({f_valid, f_err, f_rdata} !== {1'b1, 1'b0, 64'h1004}) begin
      $display("FAIL rst_regrant_resp: got %h want %h", {f_valid, f_err, f_rdata}, {1'b1, 1'b0, 64'h1004});
      fails++;
    end
    f_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [63:0] addrs [3];
    logic [63:0] wdats [3];
    logic        wes   [3];
    logic [63:0] rd;
    int a0, d0;
    logic got;
    addrs = '{64'd10, 64'd11, 64'd10};
    wdats = '{64'h111, 64'h222, 64'h0};
    wes   = '{1'b1, 1'b1, 1'b0};
    a0 = acc_cnt; d0 = dv_cnt; rd = '0;
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = wes[i]; d_addr = addrs[i]; d_wdata = wdats[i];
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick;
        if (d_valid) begin got = 1'b1; rd = d_rdata; break; end
      end
      d_req = 1'b0;
      tests++;
      if (got !== 1'b1) begin
        $display("FAIL b2b_no_valid: req %0d got %b want 1", i, got);
        fails++;
      end
      tick;
    end
    tick; tick;
    tests++;
    if (rd !== 64'h111) begin
      $display("FAIL b2b_readback: got %h want %h", rd, 64'h111);
      fails++;
    end
    tests++;
    if (acc_cnt - a0 !== 3) begin
      $display("FAIL b2b_accesses: got %0d want 3", acc_cnt - a0);
      fails++;
    end
    tests++;
    if (dv_cnt - d0 !== 3) begin
      $display("FAIL b2b_valids: got %0d want 3", dv_cnt - d0);
      fails++;
    end
    tests++;
    if (mem[11] !== 64'h222) begin
      $display("FAIL b2b_mem11: got %h want %h", mem[11], 64'h222);
      fails++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'h1000 + 64'(i);
    reset_n = 1'b0;
    test_reset;
    test_write_read;
    test_arbitration;
    test_bad_addr;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
